// File: rtl/uart_rx_frm.sv
// -----------------------------------------------------------------------------
// uart_rx_frm -- UART receiver with framing-error, break and optional parity
// handling.
//
// Frame: start bit, 8 data bits (LSB first), optional even-parity bit, one stop
// bit. The serial line is resynchronised by two flops. A start bit is
// confirmed at its centre. Each later bit is sampled one bit period after the
// previous sample.
//
// Build option:
//   UART_RX_PARITY_EN  defined   -> start, 8 data, even parity, stop
//                      undefined -> 8N1 (o_Parity_Err tied 0)
//
// Parameters:
//   CLKS_PER_BIT   clocks per serial bit (8..65535), default 87
//
// Ports:
//   i_Clock        single clock; all logic uses the rising edge
//   i_Rst_L        asynchronous active-low reset
//   i_Rx_Serial    asynchronous serial input, idle high
//   o_Rx_DV        one-clock pulse when o_Rx_Byte has been loaded with a good byte
//   o_Rx_Byte      last good byte received
//   o_Frame_Err    one-clock pulse when the stop bit samples low
//   o_Parity_Err   one-clock pulse on an even-parity mismatch
//   o_Rx_Busy      high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx_frm #(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic       i_Clock,
  input  logic       i_Rst_L,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Frame_Err,
  output logic       o_Parity_Err,
  output logic       o_Rx_Busy
);

  // The counter only has to reach CLKS_PER_BIT-1.
  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, DONE, WAIT_IDLE
  } state_e;

  state_e           state_q, state_d;
  logic             rx_meta_q, rx_sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       byte_q, byte_d;
  logic             dv_q, dv_d;
  logic             ferr_q, ferr_d;
  logic             parity_bad;

`ifdef UART_RX_PARITY_EN
  logic parity_bad_q, parity_bad_d;
  logic perr_q, perr_d;
  assign parity_bad = parity_bad_q;
`else
  assign parity_bad = 1'b0;
`endif

  // Two-flop synchroniser.
  // The flops reset to 1, which is the idle line level. A line that is low
  // when reset is released then looks like a new falling edge. A line that
  // stays high does not start a frame.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= i_Rx_Serial;
      rx_sync_q <= rx_meta_q;
    end
  end

  // NOTE: state registers use non-blocking assignments only. All flops then
  // update together, whatever order the simulator runs the processes in.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      byte_q    <= '0;
      dv_q      <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad_q <= 1'b0;
      perr_q       <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      byte_q    <= byte_d;
      dv_q      <= dv_d;
      ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
      parity_bad_q <= parity_bad_d;
      perr_q       <= perr_d;
`endif
    end
  end

  // NOTE: every signal driven here gets a default value first. A path that
  // leaves a signal unassigned would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    byte_d    = byte_q;
    dv_d      = 1'b0;
    ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_bad_d = parity_bad_q;
    perr_d       = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
`ifdef UART_RX_PARITY_EN
        parity_bad_d = 1'b0;
`endif
        if (!rx_sync_q) state_d = START;
      end

      // Check again at mid-bit so that a short low glitch is rejected.
      START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d   = '0;
          state_d = rx_sync_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DATA: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = rx_sync_q;
          bit_idx_d          = bit_idx_q + 3'd1;  // wraps 7 -> 0
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d        = '0;
          parity_bad_d = ^{shift_q, rx_sync_q};
          state_d      = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif

      // A low stop bit takes priority over a parity mismatch. Exactly one of
      // the three pulses fires per frame.
      STOP: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          if (!rx_sync_q) begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end else if (parity_bad) begin
`ifdef UART_RX_PARITY_EN
            perr_d = 1'b1;
`endif
            state_d = DONE;
          end else begin
            dv_d    = 1'b1;
            byte_d  = shift_q;
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: state_d = IDLE;

      // A break holds the line low. Wait for it to go high before looking
      // for the next start bit.
      WAIT_IDLE: if (rx_sync_q) state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  assign o_Rx_DV     = dv_q;
  assign o_Rx_Byte   = byte_q;
  assign o_Frame_Err = ferr_q;
  assign o_Rx_Busy   = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign o_Parity_Err = perr_q;
`else
  assign o_Parity_Err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frm.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_frm -- directed bench for uart_rx_frm at CLKS_PER_BIT=87 with a
// 100 ns clock. The serial line is driven on the falling clock edge. A monitor
// samples outputs on the falling edge. It counts each output pulse and logs
// every byte reported with o_Rx_DV.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx_frm;

  localparam int CPB = 87;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       frame_err;
  logic       parity_err;
  logic       rx_busy;

  int checks   = 0;
  int failures = 0;

  int         dv_cnt   = 0;
  int         ferr_cnt = 0;
  int         perr_cnt = 0;
  int         excl_cnt = 0;
  logic [7:0] dv_bytes[$];

  uart_rx_frm #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock      (clk),
    .i_Rst_L      (rst_n),
    .i_Rx_Serial  (rx),
    .o_Rx_DV      (rx_dv),
    .o_Rx_Byte    (rx_byte),
    .o_Frame_Err  (frame_err),
    .o_Parity_Err (parity_err),
    .o_Rx_Busy    (rx_busy)
  );

  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_dv) begin
        dv_cnt++;
        dv_bytes.push_back(rx_byte);
      end
      if (frame_err)  ferr_cnt++;
      if (parity_err) perr_cnt++;
      if ((32'(rx_dv) + 32'(frame_err) + 32'(parity_err)) > 1) excl_cnt++;
    end
  end

  function automatic logic even_par(input logic [7:0] d);
    return ^d;
  endfunction

  task automatic hold_line(input logic v, input int clks);
    rx = v;
    repeat (clks) @(negedge clk);
  endtask

  // One complete frame. The parity bit is sent only in the parity build.
  task automatic send_frame(input logic [7:0] data, input logic par, input logic stop_val);
    hold_line(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold_line(data[i], CPB);
`ifdef UART_RX_PARITY_EN
    hold_line(par, CPB);
`else
    if (par === 1'bx) hold_line(1'b1, 0);  // parity argument unused in 8N1
`endif
    hold_line(stop_val, CPB);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", rx_busy); end
    checks++; if (rx_byte !== 8'h00) begin failures++; $display("FAIL reset_byte got=%h exp=00", rx_byte); end
    checks++; if ({rx_dv, frame_err, parity_err} !== 3'b000) begin failures++;
      $display("FAIL reset_pulses got=%b exp=000", {rx_dv, frame_err, parity_err}); end
    rst_n = 1'b1;
    hold_line(1'b1, 2 * CPB);
    checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL idle_after_reset busy got=%b exp=0", rx_busy); end
  endtask

  task automatic test_single_byte();
    int dv0 = dv_cnt, fe0 = ferr_cnt, pe0 = perr_cnt;
    send_frame(8'h3F, even_par(8'h3F), 1'b1);
    hold_line(1'b1, CPB);
    checks++; if (dv_cnt - dv0 !== 1) begin failures++; $display("FAIL single_dv_count got=%0d exp=1", dv_cnt - dv0); end
    checks++; if (rx_byte !== 8'h3F) begin failures++; $display("FAIL single_byte got=%h exp=3f", rx_byte); end
    checks++; if ((ferr_cnt - fe0) + (perr_cnt - pe0) !== 0) begin failures++;
      $display("FAIL single_err_pulses got=%0d exp=0", (ferr_cnt - fe0) + (perr_cnt - pe0)); end
    checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL single_busy_after got=%b exp=0", rx_busy); end
  endtask

  task automatic test_glitch();
    int dv0 = dv_cnt, fe0 = ferr_cnt, pe0 = perr_cnt;
    bit busy_seen = 0;
    int waited = 0;
    hold_line(1'b0, 10);
    if (rx_busy === 1'b1) busy_seen = 1;
    hold_line(1'b0, 10);
    if (rx_busy === 1'b1) busy_seen = 1;
    rx = 1'b1;
    while (rx_busy !== 1'b0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checks++; if (!busy_seen) begin failures++; $display("FAIL glitch_busy_rise got=0 exp=1"); end
    checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL glitch_busy_timeout busy=%b after %0d clks exp=0", rx_busy, waited); end
    hold_line(1'b1, 2 * CPB);
    checks++; if ((dv_cnt - dv0) + (ferr_cnt - fe0) + (perr_cnt - pe0) !== 0) begin failures++;
      $display("FAIL glitch_pulses got=%0d exp=0", (dv_cnt - dv0) + (ferr_cnt - fe0) + (perr_cnt - pe0)); end
  endtask

  task automatic test_frame_err();
    int dv0, fe0;
    send_frame(8'h3F, even_par(8'h3F), 1'b1);
    hold_line(1'b1, CPB);
    dv0 = dv_cnt;
    fe0 = ferr_cnt;
    send_frame(8'hAB, even_par(8'hAB), 1'b0);  // first low stop bit-time
    hold_line(1'b0, CPB);                      // second low bit-time
    checks++; if (ferr_cnt - fe0 !== 1) begin failures++; $display("FAIL ferr_count got=%0d exp=1", ferr_cnt - fe0); end
    checks++; if (dv_cnt - dv0 !== 0) begin failures++; $display("FAIL ferr_no_dv got=%0d exp=0", dv_cnt - dv0); end
    checks++; if (rx_byte !== 8'h3F) begin failures++; $display("FAIL ferr_byte_kept got=%h exp=3f", rx_byte); end
    checks++; if (rx_busy !== 1'b1) begin failures++; $display("FAIL ferr_wait_idle busy got=%b exp=1", rx_busy); end
    hold_line(1'b1, 10);
    checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL ferr_release busy got=%b exp=0", rx_busy); end
    hold_line(1'b1, 2 * CPB);
  endtask

  task automatic test_back_to_back();
    int dv0 = dv_cnt;
    int n0  = dv_bytes.size();
    send_frame(8'h00, even_par(8'h00), 1'b1);
    send_frame(8'hFF, even_par(8'hFF), 1'b1);
    hold_line(1'b1, CPB);
    checks++; if (dv_cnt - dv0 !== 2) begin failures++; $display("FAIL b2b_dv_count got=%0d exp=2", dv_cnt - dv0); end
    checks++; if (dv_bytes.size() < n0 + 2 || dv_bytes[n0] !== 8'h00) begin failures++;
      $display("FAIL b2b_first_byte got=%h exp=00", (dv_bytes.size() > n0) ? dv_bytes[n0] : 8'hxx); end
    checks++; if (dv_bytes.size() < n0 + 2 || dv_bytes[n0+1] !== 8'hFF) begin failures++;
      $display("FAIL b2b_second_byte got=%h exp=ff", (dv_bytes.size() > n0 + 1) ? dv_bytes[n0+1] : 8'hxx); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d = 8'h55;
    int dv0;
    hold_line(1'b0, CPB);
    for (int i = 0; i < 4; i++) hold_line(d[i], CPB);
    hold_line(d[4], 40);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", rx_busy); end
    checks++; if (rx_byte !== 8'h00) begin failures++; $display("FAIL midrst_byte got=%h exp=00", rx_byte); end
    rx = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hold_line(1'b1, 2 * CPB);
    dv0 = dv_cnt;
    send_frame(8'hA5, even_par(8'hA5), 1'b1);
    hold_line(1'b1, CPB);
    checks++; if (dv_cnt - dv0 !== 1) begin failures++; $display("FAIL midrst_dv_count got=%0d exp=1", dv_cnt - dv0); end
    checks++; if (rx_byte !== 8'hA5) begin failures++; $display("FAIL midrst_byte_after got=%h exp=a5", rx_byte); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int dv0 = dv_cnt, pe0 = perr_cnt;
    send_frame(8'h07, 1'b1, 1'b1);
    hold_line(1'b1, CPB);
    checks++; if (dv_cnt - dv0 !== 1) begin failures++; $display("FAIL par_good_dv got=%0d exp=1", dv_cnt - dv0); end
    checks++; if (rx_byte !== 8'h07) begin failures++; $display("FAIL par_good_byte got=%h exp=07", rx_byte); end
    dv0 = dv_cnt;
    send_frame(8'h07, 1'b0, 1'b1);
    hold_line(1'b1, CPB);
    checks++; if (perr_cnt - pe0 !== 1) begin failures++; $display("FAIL par_bad_perr got=%0d exp=1", perr_cnt - pe0); end
    checks++; if (dv_cnt - dv0 !== 0) begin failures++; $display("FAIL par_bad_no_dv got=%0d exp=0", dv_cnt - dv0); end
    checks++; if (rx_byte !== 8'h07) begin failures++; $display("FAIL par_bad_byte got=%h exp=07", rx_byte); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_byte();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_midframe();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    checks++; if (excl_cnt !== 0) begin failures++; $display("FAIL pulse_exclusive got=%0d exp=0", excl_cnt); end
`ifndef UART_RX_PARITY_EN
    checks++; if (perr_cnt !== 0) begin failures++; $display("FAIL perr_tied_low got=%0d exp=0", perr_cnt); end
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
